// File: rtl/fp16_multiplier.sv
// Sequential fp16 multiplier: one product in flight, fixed 4-cycle latency.
// Round-toward-zero arithmetic. Subnormal inputs count as zero, inf/NaN inputs
// saturate. The flag outputs follow the downstream fp16 adder stage.
module fp16_multiplier #(
   parameter int BIAS = 15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        clk_en,
   input  logic [15:0] dataa,
   input  logic [15:0] datab,
   output logic [15:0] result,
   output logic        sign,
   output logic        overflow,
   output logic        underflow,
   output logic        zero,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {StIdle, StUnpack, StMult, StNorm} state_e;

   state_e state_q;

   // Operands latched on the accepting edge
   logic [15:0] a_q, b_q;

   // Unpacked fields
   logic        s_q;
   logic [4:0]  ea_q, eb_q;
   logic [10:0] siga_q, sigb_q;
   logic        zero_op_q;
   logic        inf_op_q;

   // Upper 12 bits of the 22-bit significand product; the rest is truncated anyway
   logic [11:0]       prod_q;
   logic signed [6:0] exp_q;

   // Registered outputs
   logic [15:0] result_q;
   logic        sign_q;
   logic        overflow_q;
   logic        underflow_q;
   logic        zero_q;
   logic        busy_q;
   logic        done_q;

   // Normalisation and result selection
   logic signed [6:0] exp_fin;
   logic [9:0]        mant_n;
   logic [15:0]       res_d;
   logic              ovf_d;
   logic              unf_d;
   logic              zero_d;

   // Normalise the product and pick the result case in priority order
   always_comb begin
      exp_fin = exp_q + 7'(prod_q[11]);
      mant_n  = prod_q[11] ? prod_q[10:1] : prod_q[9:0];
      res_d   = 16'h0000;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      zero_d  = 1'b0;
      if (zero_op_q) begin
         zero_d = 1'b1;
      end else if (inf_op_q || (exp_fin > 7'sd30)) begin
         res_d = {s_q, 5'h1F, 10'h000};
         ovf_d = 1'b1;
      end else if (exp_fin < 7'sd1) begin
         // Underflow flushes to +0, sign dropped
         unf_d  = 1'b1;
         zero_d = 1'b1;
      end else begin
         res_d = {s_q, exp_fin[4:0], mant_n};
      end
   end

   // Control FSM plus datapath pipeline registers and registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         a_q         <= 16'h0000;
         b_q         <= 16'h0000;
         s_q         <= 1'b0;
         ea_q        <= 5'h00;
         eb_q        <= 5'h00;
         siga_q      <= 11'h000;
         sigb_q      <= 11'h000;
         zero_op_q   <= 1'b0;
         inf_op_q    <= 1'b0;
         prod_q      <= 12'h000;
         exp_q       <= 7'sd0;
         result_q    <= 16'h0000;
         sign_q      <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         zero_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (clk_en) begin
                  a_q     <= dataa;
                  b_q     <= datab;
                  busy_q  <= 1'b1;
                  state_q <= StUnpack;
               end
            end
            StUnpack: begin
               s_q       <= a_q[15] ^ b_q[15];
               ea_q      <= a_q[14:10];
               eb_q      <= b_q[14:10];
               // Hidden bit only for normal numbers; subnormals are flagged as zero below
               siga_q    <= {|a_q[14:10], a_q[9:0]};
               sigb_q    <= {|b_q[14:10], b_q[9:0]};
               zero_op_q <= (a_q[14:10] == 5'h00) || (b_q[14:10] == 5'h00);
               inf_op_q  <= (a_q[14:10] == 5'h1F) || (b_q[14:10] == 5'h1F);
               state_q   <= StMult;
            end
            StMult: begin
               prod_q  <= 12'((22'(siga_q) * 22'(sigb_q)) >> 10);
               exp_q   <= 7'({2'b00, ea_q}) + 7'({2'b00, eb_q}) - 7'(BIAS);
               state_q <= StNorm;
            end
            StNorm: begin
               result_q    <= res_d;
               sign_q      <= res_d[15];
               overflow_q  <= ovf_d;
               underflow_q <= unf_d;
               zero_q      <= zero_d;
               busy_q      <= 1'b0;
               done_q      <= 1'b1;
               state_q     <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign result    = result_q;
   assign sign      = sign_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign zero      = zero_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_fp16_multiplier.sv
// Self-checking bench for fp16_multiplier: a value-level fp16 product model and
// an acceptance/timing model check every output on every cycle.
module tb_fp16_multiplier;

   logic        clock;
   logic        reset;
   logic        clk_en;
   logic [15:0] dataa;
   logic [15:0] datab;
   logic [15:0] result;
   logic        sign;
   logic        overflow;
   logic        underflow;
   logic        zero;
   logic        busy;
   logic        done;

   fp16_multiplier dut (
      .clock     (clock),
      .reset     (reset),
      .clk_en    (clk_en),
      .dataa     (dataa),
      .datab     (datab),
      .result    (result),
      .sign      (sign),
      .overflow  (overflow),
      .underflow (underflow),
      .zero      (zero),
      .busy      (busy),
      .done      (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp  = 0;
   int n_fail = 0;
   int done_cnt = 0;

   typedef struct {
      logic [18:0] exp;
      int          due;
   } pend_t;

   // Expected product as {result[15:0], overflow, underflow, zero}
   function automatic logic [18:0] fp_mul_model(input logic [15:0] a, input logic [15:0] b);
      int          ea, eb, e, msb;
      logic [21:0] p;
      logic        s;
      logic [9:0]  m;
      ea = int'(a[14:10]);
      eb = int'(b[14:10]);
      if (ea == 0 || eb == 0) return 19'h00001;
      s = a[15] ^ b[15];
      if (ea == 31 || eb == 31) return {s, 5'h1F, 10'h000, 3'b100};
      p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
      msb = 0;
      for (int i = 0; i < 22; i++) if (p[i]) msb = i;
      // value = p * 2^(ea+eb-30-20+...) ; leading one at msb gives exponent shift msb-20
      e = ea + eb - 15 + (msb - 20);
      m = 10'(p >> (msb - 10));
      if (e >= 31) return {s, 5'h1F, 10'h000, 3'b100};
      if (e <= 0) return {16'h0000, 3'b011};
      return {s, 5'(e), m, 3'b000};
   endfunction

   function automatic logic [15:0] rand_fp();
      logic [4:0] e;
      if ($urandom_range(0, 1) == 1) e = 5'($urandom_range(0, 31));
      else e = 5'($urandom_range(8, 22));
      return {1'($urandom_range(0, 1)), e, 10'($urandom)};
   endfunction

   task automatic check(input string name, input logic [21:0] got, input logic [21:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   // Timing/value monitor: tracks accepted requests and checks all outputs every cycle
   initial begin
      pend_t       q[$];
      pend_t       ent;
      int          cyc;
      int          free_at;
      logic [18:0] held;
      logic [21:0] expv;
      logic [21:0] got;
      logic        d_e;
      logic        b_e;
      cyc = 0;
      free_at = 0;
      held = '0;
      forever begin
         @(posedge clock);
         cyc++;
         if (reset) begin
            q.delete();
            free_at = 0;
         end else if (clk_en && cyc >= free_at) begin
            ent.exp = fp_mul_model(dataa, datab);
            ent.due = cyc + 3;
            q.push_back(ent);
            free_at = cyc + 4;
         end
         @(negedge clock);
         if (reset) begin
            q.delete();
            free_at = 0;
            held = '0;
            expv = '0;
         end else begin
            d_e = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
               held = q[0].exp;
               void'(q.pop_front());
               d_e = 1'b1;
            end
            b_e = (q.size() > 0);
            expv = {held[18:3], held[18], held[2:0], b_e, d_e};
         end
         got = {result, sign, overflow, underflow, zero, busy, done};
         n_cmp++;
         if (got !== expv) begin
            n_fail++;
            $display("FAIL cycle_check @%0d: got %h, expected %h", cyc, got, expv);
         end
         if (done === 1'b1) done_cnt++;
      end
   end

   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input string name,
                         input logic [21:0] want);
      bit seen;
      @(negedge clock);
      clk_en = 1'b1;
      dataa  = a;
      datab  = b;
      @(negedge clock);
      clk_en = 1'b0;
      dataa  = rand_fp();
      datab  = rand_fp();
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s_timeout: got no done, expected done within 8 cycles", name);
      end else begin
         check(name, {result, sign, overflow, underflow, zero, busy, done}, want);
      end
   endtask

   initial begin
      int cnt0;
      reset  = 1'b1;
      clk_en = 1'b0;
      dataa  = 16'h0000;
      datab  = 16'h0000;
      repeat (3) @(posedge clock);
      #1;
      check("reset_state", {result, sign, overflow, underflow, zero, busy, done}, 22'h0);
      reset = 1'b0;

      // Pin the model itself with hand-computed values
      check("model_1p5x2", {3'b000, fp_mul_model(16'h3E00, 16'h4000)}, {3'b000, 16'h4200, 3'b000});
      check("model_neg", {3'b000, fp_mul_model(16'hBE00, 16'h3E00)}, {3'b000, 16'hC080, 3'b000});
      check("model_ovf", {3'b000, fp_mul_model(16'h7800, 16'h7800)}, {3'b000, 16'h7C00, 3'b100});
      check("model_unf", {3'b000, fp_mul_model(16'h0400, 16'h0400)}, {3'b000, 16'h0000, 3'b011});

      run_op(16'h3E00, 16'h4000, "mul_1p5x2", {16'h4200, 1'b0, 3'b000, 1'b0, 1'b1});
      run_op(16'hBE00, 16'h3E00, "mul_neg", {16'hC080, 1'b1, 3'b000, 1'b0, 1'b1});
      run_op(16'h7800, 16'h7800, "ovf_pos", {16'h7C00, 1'b0, 3'b100, 1'b0, 1'b1});
      run_op(16'hF800, 16'h7800, "ovf_neg", {16'hFC00, 1'b1, 3'b100, 1'b0, 1'b1});
      run_op(16'h0400, 16'h0400, "underflow", {16'h0000, 1'b0, 3'b011, 1'b0, 1'b1});
      run_op(16'h0000, 16'hC000, "zero_op", {16'h0000, 1'b0, 3'b001, 1'b0, 1'b1});
      run_op(16'h7C00, 16'h0000, "inf_x_zero", {16'h0000, 1'b0, 3'b001, 1'b0, 1'b1});
      run_op(16'h7E00, 16'h3C00, "nan_in", {16'h7C00, 1'b0, 3'b100, 1'b0, 1'b1});

      // clk_en held for 12 cycles: accepts at E, E+4, E+8 only
      @(negedge clock);
      #1;
      cnt0 = done_cnt;
      clk_en = 1'b1;
      dataa  = rand_fp();
      datab  = rand_fp();
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         dataa = rand_fp();
         datab = rand_fp();
         if (i == 11) clk_en = 1'b0;
      end
      repeat (6) @(negedge clock);
      #1;
      check("burst_dones", 22'(done_cnt - cnt0), 22'd3);

      // Reset two edges after acceptance abandons the product
      @(negedge clock);
      clk_en = 1'b1;
      dataa  = 16'h4000;
      datab  = 16'h4000;
      @(posedge clock);
      #1;
      clk_en = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      check("reset_mid", {result, sign, overflow, underflow, zero, busy, done}, 22'h0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      cnt0 = done_cnt;
      repeat (5) @(negedge clock);
      #1;
      check("no_done_after_reset", 22'(done_cnt - cnt0), 22'd0);
      run_op(16'h3C00, 16'h3C00, "after_reset", {16'h3C00, 1'b0, 3'b000, 1'b0, 1'b1});

      // Randomized traffic, including back-to-back requests
      for (int i = 0; i < 400; i++) begin
         @(negedge clock);
         clk_en = 1'($urandom_range(0, 1));
         dataa  = rand_fp();
         datab  = rand_fp();
      end
      @(negedge clock);
      clk_en = 1'b0;
      repeat (8) @(negedge clock);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
